max_pooling_stream: RTL and testbench
=====================================

# max_pooling_stream

Parametrised, handshaked successor to the fixed 48-to-24 float32 max-pooling stage in the CNN datapath. Accepts one feature-map row of N_IN IEEE-754 binary32 words per beat. Always pools horizontally by 2. When configured for 2-D pooling, it also pools vertically across row pairs using an internal row buffer. Sits between the activation stage and the next convolution layer and applies backpressure through a valid/ready handshake.

## Interface
- `DATA_W`, default 32: element width; float32 encoding; only 32 supported.
- `N_IN`, default 48: elements per input row; must be even and ≥ 2.
- `POOL_ROWS`, default 2: 1 selects 1x2 pooling; 2 selects 2x2 pooling.
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `valid_i` input, 1 bit: input row valid.
- `ready_o` output, 1 bit: block can accept a row.
- `sof_i` input, 1 bit: qualifies the current input beat as the first row of a feature map.
- `multi_input_data` input, N_IN*DATA_W bits: element k is at [k*DATA_W +: DATA_W].
- `valid_o` output, 1 bit: output row valid.
- `ready_i` input, 1 bit: downstream accepts the row.
- `multi_output_data` output, (N_IN/2)*DATA_W bits: element j is at [j*DATA_W +: DATA_W].

## Operation
- Acceptance: a beat is accepted when `valid_i && ready_o`. A beat is emitted when `valid_o && ready_i`.
- Comparison key:
  - Sign 0: key = {1'b1, bits[30:0]}.
  - Sign 1: key = ~bits.
  - The larger unsigned key wins. Ties select the lower-index operand.
  - +0 beats -0. NaNs have no special handling and order by key.
- Horizontal max: h[j] = max(in[2j], in[2j+1]) for j = 0..N_IN/2-1.
- Row phase register `phase` is 1 bit:
  - An accepted beat with `sof_i`=1 is treated as phase 0 regardless of the register.
  - Every accepted beat toggles the phase. With `sof_i`=1, the next phase is 1.
- POOL_ROWS=1: every accepted beat loads h into the output register and sets `valid_o`.
- POOL_ROWS=2:
  - Phase-0 beat: h is written to the row buffer (N_IN/2 words). No output is produced.
  - Phase-1 beat: the output register loads out[j] = max(buf[j], h[j]) and `valid_o` is set. For ties, buf, the earlier row, wins.
- `ready_o` = !valid_o || ready_i. This is combinational, so the block sustains full throughput.
- The output register holds its data stable while `valid_o && !ready_i`.
- `valid_o` clears on emission unless a new output-producing beat is accepted in the same cycle.
- Simultaneous emit and accept: the new data replaces the old and `valid_o` stays 1.
- `sof_i` on a phase-1 slot discards the buffered half-pair, with no output and no error. That beat restarts at phase 0.
- Reset is asynchronous and abandons any half-pair in progress.

## Timing
- Reset values:
  - `valid_o`=0.
  - `multi_output_data`=0.
  - `phase`=0.
  - Row buffer = 0.
  - `ready_o`=1, derived from `valid_o`.
- Latency: `valid_o` rises on the edge that accepts the output-producing beat, so output is visible 1 cycle after acceptance.
- Throughput:
  - POOL_ROWS=1: one output row per cycle.
  - POOL_ROWS=2: one output row per 2 accepted rows.
- A phase-0 beat with `valid_o && !ready_i` is stalled, because `ready_o`=0.
- No combinational path exists from `valid_i` to `valid_o`. The only combinational path to `ready_o` is from `ready_i`.

## Configuration
- `MAXPOOL_RELU_EN`:
  - Defined: each output word is clamped so that any word with sign bit 1 (including -0 and negative NaN) is replaced by 32'h00000000 before registering.
  - Undefined: pooled values pass unmodified. The comparator and handshake are identical in both builds.

## Test plan
- 1-D sign compare: POOL_ROWS=1, all pairs {0x8C000000, 0x0C000000}, `ready_i`=1 → every output word is 0x0C000000 one cycle later. With `MAXPOOL_RELU_EN` and all pairs {0x8C000000, 0xC0000000} → every output word is 0.
- 1-D magnitude and tie: pairs {0x0B000000, 0x0A000000} → 0x0B000000. Pair {0x80000000, 0x00000000} → 0x00000000. Pair {0x3F800000, 0x3F800000} → 0x3F800000.
- 2-D pooling: row 0 (with `sof_i`) = all 0x40000000; row 1 = pairs {0x40400000, 0xC0800000} → one output row of 0x40400000. `valid_o` stays low after row 0.
- Backpressure: hold `ready_i`=0 with `valid_o`=1 and offer a new row → `ready_o`=0, output data stable for 5 cycles. Release → back-to-back rows stream at one per cycle (1-D).
- Resync: in 2-D mode, send row A, then row B with `sof_i`=1, then row C → the single output is max(B, C) and A is discarded.
- Async reset: assert `reset` mid-pair between clock edges → `valid_o`=0 and the output is 0 immediately. The next beat is treated as phase 0.

Source files
------------

// File: rtl/max_pooling_stream.sv
// Streaming float32 max-pooling stage: 1x2 (POOL_ROWS=1) or 2x2 (POOL_ROWS=2) with valid/ready.
// Optional build macro MAXPOOL_RELU_EN clamps any pooled word with sign bit set to zero.
module max_pooling_stream #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned N_IN      = 48,
  parameter int unsigned POOL_ROWS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic                         sof_i,
  input  logic [N_IN*DATA_W-1:0]       multi_input_data,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [(N_IN/2)*DATA_W-1:0]   multi_output_data
);
  localparam int unsigned NOut = N_IN / 2;

  logic                   r_valid;
  logic                   r_phase;
  logic [NOut*DATA_W-1:0] r_data;
  logic [NOut*DATA_W-1:0] r_buf;
  logic [NOut*DATA_W-1:0] w_h;
  logic [NOut*DATA_W-1:0] w_out;
  logic                   w_accept;
  logic                   w_phase_eff;
  logic                   w_produce;

  // Monotonic unsigned key: +0 sorts above -0, negatives reverse their magnitude order.
  function automatic logic [DATA_W-1:0] key_f(input logic [DATA_W-1:0] b);
    return b[DATA_W-1] ? ~b : {1'b1, b[DATA_W-2:0]};
  endfunction

  // Ties keep a, the lower-index (or earlier-row) operand.
  function automatic logic [DATA_W-1:0] max_f(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return (key_f(b) > key_f(a)) ? b : a;
  endfunction

  assign ready_o     = !r_valid || ready_i;
  assign w_accept    = valid_i && ready_o;
  assign w_phase_eff = sof_i ? 1'b0 : r_phase;
  assign w_produce   = w_accept && ((POOL_ROWS == 1) || w_phase_eff);

  always_comb begin
    w_h   = '0;
    w_out = '0;
    for (int j = 0; j < int'(NOut); j++) begin
      w_h[j*DATA_W +: DATA_W] = max_f(multi_input_data[(2*j)*DATA_W +: DATA_W],
                                      multi_input_data[(2*j+1)*DATA_W +: DATA_W]);
      w_out[j*DATA_W +: DATA_W] = (POOL_ROWS == 1) ? w_h[j*DATA_W +: DATA_W]
                                : max_f(r_buf[j*DATA_W +: DATA_W], w_h[j*DATA_W +: DATA_W]);
`ifdef MAXPOOL_RELU_EN
      if (w_out[(j+1)*DATA_W-1]) w_out[j*DATA_W +: DATA_W] = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_phase <= 1'b0;
      r_data  <= '0;
      r_buf   <= '0;
    end else begin
      if (w_accept) r_phase <= !w_phase_eff;
      if (w_accept && !w_produce) r_buf <= w_h;
      if (w_produce) begin
        r_data  <= w_out;
        r_valid <= 1'b1;
      end else if (ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign valid_o           = r_valid;
  assign multi_output_data = r_data;

endmodule

// File: tb/tb_max_pooling_stream.sv
// Bench for max_pooling_stream: 1x2 and 2x2 instances driven by shared stimulus and
// checked against an ordered-value reference model plus directed vectors.
module tb_max_pooling_stream;
  localparam int unsigned DW = 32;
  localparam int unsigned NI = 8;
  localparam int unsigned NO = NI / 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            valid_i, sof_i, ready_i;
  logic [NI*DW-1:0] din;
  logic            rdy1, vld1, rdy2, vld2;
  logic [NO*DW-1:0] dout1, dout2;

  always #5 clk = ~clk;

  max_pooling_stream #(.DATA_W(DW), .N_IN(NI), .POOL_ROWS(1)) u_dut1 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(rdy1), .sof_i(sof_i),
    .multi_input_data(din), .valid_o(vld1), .ready_i(ready_i), .multi_output_data(dout1));

  max_pooling_stream #(.DATA_W(DW), .N_IN(NI), .POOL_ROWS(2)) u_dut2 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(rdy2), .sof_i(sof_i),
    .multi_input_data(din), .valid_o(vld2), .ready_i(ready_i), .multi_output_data(dout2));

  int checks = 0;
  int errors = 0;

  // Reference model state: index 0 = 1x2 instance, index 1 = 2x2 instance.
  bit               m_v [2];
  logic [NO*DW-1:0] m_d [2];
  bit               m_pend;
  logic [NO*DW-1:0] m_buf;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;
  vec_t tbl [6];

  // Float order as a signed integer: sign-magnitude with -0 just below +0.
  function automatic longint ord(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m - 1 : m;
  endfunction

  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    return (ord(b) > ord(a)) ? b : a;
  endfunction

  function automatic logic [NO*DW-1:0] pool(input logic [NI*DW-1:0] d);
    logic [NO*DW-1:0] r;
    for (int j = 0; j < int'(NO); j++)
      r[j*DW +: DW] = fmax(d[(2*j)*DW +: DW], d[(2*j+1)*DW +: DW]);
    return r;
  endfunction

  function automatic logic [NO*DW-1:0] pair_max(input logic [NO*DW-1:0] a,
                                                input logic [NO*DW-1:0] b);
    logic [NO*DW-1:0] r;
    for (int j = 0; j < int'(NO); j++) r[j*DW +: DW] = fmax(a[j*DW +: DW], b[j*DW +: DW]);
    return r;
  endfunction

  function automatic logic [NO*DW-1:0] relu_row(input logic [NO*DW-1:0] a);
    logic [NO*DW-1:0] r;
    r = a;
`ifdef MAXPOOL_RELU_EN
    for (int j = 0; j < int'(NO); j++) if (a[j*DW+DW-1]) r[j*DW +: DW] = '0;
`endif
    return r;
  endfunction

  function automatic logic [NI*DW-1:0] fill(input logic [31:0] a, input logic [31:0] b);
    logic [NI*DW-1:0] r;
    for (int j = 0; j < int'(NO); j++) begin
      r[(2*j)*DW +: DW]   = a;
      r[(2*j+1)*DW +: DW] = b;
    end
    return r;
  endfunction

  function automatic logic [NO*DW-1:0] rep(input logic [31:0] e);
    logic [NO*DW-1:0] r;
    for (int j = 0; j < int'(NO); j++) r[j*DW +: DW] = e;
    return r;
  endfunction

  function automatic logic [NI*DW-1:0] rand_row();
    logic [NI*DW-1:0] r;
    logic [31:0] w;
    for (int k = 0; k < int'(NI); k++) begin
      w = $urandom;
      case ($urandom_range(0, 9))
        0: w = 32'h8000_0000;
        1: w = 32'h0000_0000;
        2: if (k > 0) w = r[(k-1)*DW +: DW];
        default: ;
      endcase
      r[k*DW +: DW] = w;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [NO*DW-1:0] act,
                     input logic [NO*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_v[0] = 0; m_v[1] = 0;
    m_d[0] = '0; m_d[1] = '0;
    m_pend = 0;
    m_buf  = '0;
  endtask

  // Applies the rules for one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic [NO*DW-1:0] h;
    bit acc;
    h   = pool(din);
    acc = valid_i && (!m_v[0] || ready_i);
    if (acc) begin
      m_d[0] = relu_row(h);
      m_v[0] = 1;
    end else if (ready_i) m_v[0] = 0;
    acc = valid_i && (!m_v[1] || ready_i);
    if (acc) begin
      if (sof_i) m_pend = 0;
      if (!m_pend) begin
        m_buf  = h;
        m_pend = 1;
        m_v[1] = 0;
      end else begin
        m_d[1] = relu_row(pair_max(m_buf, h));
        m_v[1] = 1;
        m_pend = 0;
      end
    end else if (ready_i) m_v[1] = 0;
  endtask

  // Entered and left at posedge+1.
  task automatic cyc(input logic v, input logic s, input logic r, input logic [NI*DW-1:0] d);
    valid_i = v; sof_i = s; ready_i = r; din = d;
    #4;
    chk("ready1", rdy1, !m_v[0] || r);
    chk("ready2", rdy2, !m_v[1] || r);
    @(posedge clk);
    model_edge();
    #1;
    chk("valid1", vld1, m_v[0]);
    chk("data1", dout1, m_d[0]);
    chk("valid2", vld2, m_v[1]);
    chk("data2", dout2, m_d[1]);
  endtask

  initial begin
    logic [NI*DW-1:0] ra, rb, rc, rp, rq;
    logic [NO*DW-1:0] hold;

    tbl[0] = '{32'h8C00_0000, 32'h0C00_0000, 32'h0C00_0000};
`ifdef MAXPOOL_RELU_EN
    tbl[1] = '{32'h8C00_0000, 32'hC000_0000, 32'h0000_0000};
`else
    tbl[1] = '{32'h8C00_0000, 32'hC000_0000, 32'h8C00_0000};
`endif
    tbl[2] = '{32'h0B00_0000, 32'h0A00_0000, 32'h0B00_0000};
    tbl[3] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
    tbl[4] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
    tbl[5] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};

    reset = 1'b1; valid_i = 0; sof_i = 0; ready_i = 1; din = '0;
    model_reset();
    #8;
    chk("rst_valid1", vld1, 1'b0);
    chk("rst_data1", dout1, '0);
    chk("rst_ready1", rdy1, 1'b1);
    chk("rst_valid2", vld2, 1'b0);
    chk("rst_data2", dout2, '0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 1, fill(tbl[i].a, tbl[i].b));
      chk($sformatf("tbl%0d", i), dout1, rep(tbl[i].e));
      chk($sformatf("tbl%0d_v", i), vld1, 1'b1);
    end

    // 2x2 pooling of two directed rows.
    cyc(1, 1, 1, fill(32'h4000_0000, 32'h4000_0000));
    chk("pool2_row0_v", vld2, 1'b0);
    cyc(1, 0, 1, fill(32'h4040_0000, 32'hC080_0000));
    chk("pool2_out", dout2, rep(32'h4040_0000));
    chk("pool2_v", vld2, 1'b1);

    // Backpressure then streaming release.
    ra = rand_row();
    cyc(1, 0, 1, ra);
    hold = relu_row(pool(ra));
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, rand_row());
      chk("bp_hold", dout1, hold);
      chk("bp_ready", rdy1, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      rb = rand_row();
      cyc(1, 0, 1, rb);
      chk("stream", dout1, relu_row(pool(rb)));
      chk("stream_v", vld1, 1'b1);
    end

    // Resync: A is discarded when B arrives with sof.
    ra = rand_row(); rb = rand_row(); rc = rand_row();
    cyc(1, 1, 1, ra);
    cyc(1, 1, 1, rb);
    chk("resync_b_v", vld2, 1'b0);
    cyc(1, 0, 1, rc);
    chk("resync_out", dout2, relu_row(pair_max(pool(rb), pool(rc))));

    // Asynchronous reset mid-pair.
    cyc(1, 1, 1, fill(32'h3F80_0000, 32'h4000_0000));
    valid_i = 0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("areset_v1", vld1, 1'b0);
    chk("areset_d1", dout1, '0);
    chk("areset_r1", rdy1, 1'b1);
    chk("areset_v2", vld2, 1'b0);
    #2 reset = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    rp = rand_row(); rq = rand_row();
    cyc(1, 0, 1, rp);
    chk("post_rst_ph0", vld2, 1'b0);
    cyc(1, 0, 1, rq);
    chk("post_rst_out", dout2, relu_row(pair_max(pool(rp), pool(rq))));

    for (int i = 0; i < 300; i++)
      cyc(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 7) == 0),
          logic'($urandom_range(0, 3) != 0), rand_row());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
